// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU and load-return writeback paths.
// Latency: 1 cycle from handshake to registered write; conflicts counted per cycle.
// Backpressure: combinational ready, round-robin on conflict; the loser holds valid.
module wb_port_arbiter #(
    parameter int WORD     = 64,
    parameter int REG_ADDR = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_ADDR-1:0] alu_rd,
    input  logic [WORD-1:0]     alu_result,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_ADDR-1:0] ld_rd,
    input  logic [WORD-1:0]     read_data,
    output logic                wb_reg_write,
    output logic [REG_ADDR-1:0] wb_rd,
    output logic [WORD-1:0]     write_back,
    output logic                wb_src,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam logic [REG_ADDR-1:0] ZERO_IDX = REG_ADDR'(ZERO_REG);

    // last_winner: 0 = ALU won the previous conflict, 1 = load did
    logic                last_winner_q, last_winner_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic [REG_ADDR-1:0] wb_rd_q, wb_rd_d;
    logic [WORD-1:0]     write_back_q, write_back_d;
    logic                wb_src_q, wb_src_d;
    logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;
    logic                conflict;

    always_comb begin
        conflict  = alu_valid && ld_valid;
        alu_ready = rst_n && alu_valid && (!ld_valid || last_winner_q);
        ld_ready  = rst_n && ld_valid && (!alu_valid || !last_winner_q);

        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        write_back_d   = write_back_q;
        wb_src_d       = wb_src_q;
        if (alu_ready) begin
            wb_reg_write_d = (alu_rd != ZERO_IDX);
            wb_rd_d        = alu_rd;
            write_back_d   = alu_result;
            wb_src_d       = 1'b0;
        end else if (ld_ready) begin
            wb_reg_write_d = (ld_rd != ZERO_IDX);
            wb_rd_d        = ld_rd;
            write_back_d   = read_data;
            wb_src_d       = 1'b1;
        end

        last_winner_d  = conflict ? ld_ready : last_winner_q;
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Reset leaves last_winner at load so the ALU takes the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q  <= 1'b1;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            write_back_q   <= '0;
            wb_src_q       <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            last_winner_q  <= last_winner_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            write_back_q   <= write_back_d;
            wb_src_q       <= wb_src_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign write_back   = write_back_q;
    assign wb_src       = wb_src_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter: a reference model predicts grants
// and registered writes; a monitor pops expected writes whenever a handshake is seen.
`timescale 1ns/1ps
module tb_wb_port_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        src;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_rd, ld_rd;
    logic [63:0] alu_result, read_data;
    logic        alu_ready, ld_ready;
    logic        wb_reg_write, wb_src;
    logic [4:0]  wb_rd;
    logic [63:0] write_back;
    logic [15:0] conflict_cnt;

    logic        alu_ready2, ld_ready2, wb_reg_write2, wb_src2;
    logic [4:0]  wb_rd2;
    logic [63:0] write_back2;
    logic [1:0]  conflict_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    wb_exp_t exp_q[$];
    bit      m_last_ld;
    int      m_cnt, m_cnt2;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .read_data(read_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .write_back(write_back),
        .wb_src(wb_src), .conflict_cnt(conflict_cnt)
    );

    wb_port_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready2), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_rd(ld_rd), .read_data(read_data),
        .wb_reg_write(wb_reg_write2), .wb_rd(wb_rd2), .write_back(write_back2),
        .wb_src(wb_src2), .conflict_cnt(conflict_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_last_ld = 1'b1;
        m_cnt     = 0;
        m_cnt2    = 0;
    endfunction

    // One cycle: drive at posedge+1, check ready at +4, commit the model at the edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                        output logic ga, output logic gl, output logic dut_ga);
        wb_exp_t e;
        alu_valid = av; alu_rd = ard; alu_result = ad;
        ld_valid  = lv; ld_rd  = lrd; read_data  = ld;
        if (av && lv) begin
            ga = m_last_ld;
            gl = !m_last_ld;
        end else begin
            ga = av;
            gl = lv;
        end
        #3;
        chk("alu_ready", alu_ready, ga);
        chk("ld_ready", ld_ready, gl);
        dut_ga = alu_ready;
        @(posedge clk);
        if (av && lv) begin
            m_last_ld = gl;
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end
        if (ga) begin
            e.we = (ard != 5'd31); e.rd = ard; e.data = ad; e.src = 1'b0;
            exp_q.push_back(e);
        end else if (gl) begin
            e.we = (lrd != 5'd31); e.rd = lrd; e.data = ld; e.src = 1'b1;
            exp_q.push_back(e);
        end
        #1;
        chk("conflict_cnt", conflict_cnt, 64'(m_cnt));
        chk("conflict_cnt_sat", conflict_cnt2, 64'(m_cnt2));
    endtask

    // Monitor: handshake seen at an edge -> pop and compare the registered write.
    logic        xfer_seen = 1'b0;
    logic [4:0]  h_rd  = '0;
    logic [63:0] h_d   = '0;
    logic        h_src = 1'b0;

    always @(posedge clk)
        xfer_seen = rst_n && ((alu_valid && alu_ready) || (ld_valid && ld_ready));

    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst_n) begin
            chk("rst_wb_reg_write", wb_reg_write, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_write_back", write_back, 0);
            chk("rst_wb_src", wb_src, 0);
            chk("rst_conflict_cnt", conflict_cnt, 0);
            h_rd = '0; h_d = '0; h_src = 1'b0;
        end else if (xfer_seen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_reg_write", wb_reg_write, e.we);
                chk("wb_rd", wb_rd, e.rd);
                chk("write_back", write_back, e.data);
                chk("wb_src", wb_src, e.src);
                h_rd = e.rd; h_d = e.data; h_src = e.src;
            end
        end else begin
            chk("idle_wb_reg_write", wb_reg_write, 0);
            chk("hold_wb_rd", wb_rd, h_rd);
            chk("hold_write_back", write_back, h_d);
            chk("hold_wb_src", wb_src, h_src);
        end
    end

    initial begin
        logic        ga, gl, dga;
        logic        pa_v, pl_v;
        logic [4:0]  pa_rd, pl_rd;
        logic [63:0] pa_d, pl_d;

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_valid  = 1'b0; ld_rd  = '0; read_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Sustained conflict straight out of reset: strict alternation, ALU first.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'd1, 64'h100 + 64'(i), 1'b1, 5'd2, 64'h200 + 64'(i), ga, gl, dga);
            chk("conflict_alu_grant", dga, (i % 2 == 0));
            if (i == 3) chk("conflict_cnt_after4", conflict_cnt, 4);
        end
        chk("conflict_cnt_after6", conflict_cnt, 6);
        chk("sat_cnt_no_wrap", conflict_cnt2, 3);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);

        // Single ALU write, then an idle cycle that must hold the write port values.
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);

        // Load to the zero register: handshake completes, no write enable.
        step(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'hDEAD, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);

        // Reset lands between handshake and capture edge: the write is lost.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 64'h7777;
        #2;
        chk("pre_reset_alu_ready", alu_ready, 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_alu_ready", alu_ready, 0);
        chk("reset_wb_reg_write", wb_reg_write, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);

        // Random requesters that hold their request until granted.
        pa_v = 1'b0; pl_v = 1'b0;
        pa_rd = '0; pl_rd = '0; pa_d = '0; pl_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa_v && $urandom_range(0, 3) != 0) begin
                pa_v  = 1'b1;
                pa_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                pa_d  = {$urandom, $urandom};
            end
            if (!pl_v && $urandom_range(0, 3) != 0) begin
                pl_v  = 1'b1;
                pl_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                pl_d  = {$urandom, $urandom};
            end
            step(pa_v, pa_rd, pa_d, pl_v, pl_rd, pl_d, ga, gl, dga);
            if (ga) pa_v = 1'b0;
            if (gl) pl_v = 1'b0;
        end
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        step(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, ga, gl, dga);
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
